// File: rtl/alu_pkg.sv
// alu_pkg: op encoding, FSM states and shift classifier for multicycle_alu
package alu_pkg;
  typedef enum logic [3:0] {
    OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010, OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100, OP_SRL  = 4'b0101, OP_SUB  = 4'b0110, OP_SRA  = 4'b0111,
    OP_EQ   = 4'b1000, OP_NE   = 4'b1001, OP_SLT  = 4'b1010, OP_SLTU = 4'b1011,
    OP_GE   = 4'b1100, OP_GEU  = 4'b1101, OP_PASSB = 4'b1110, OP_RSVD = 4'b1111
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_e;
  function automatic logic is_shift(alu_op_e op);
    return op == OP_SLL || op == OP_SRL || op == OP_SRA;
  endfunction
endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core: single-cycle datapath for every non-shift op; shifts and reserved yield 0
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_ADD:   y = a + b;
      OP_XOR:   y = a ^ b;
      OP_SUB:   y = a - b;
      OP_EQ:    y[0] = a == b;
      OP_NE:    y[0] = a != b;
      OP_SLT:   y[0] = $signed(a) < $signed(b);
      OP_SLTU:  y[0] = a < b;
      OP_GE:    y[0] = $signed(a) >= $signed(b);
      OP_GEU:   y[0] = a >= b;
      OP_PASSB: y = b;
      default:  y = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: valid/ready execute ALU; single-cycle ops via alu_comb_core,
// shifts on a one-bit-per-cycle serial shifter.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        operation,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              busy
);
  localparam int SW = $clog2(DATA_W);
  alu_state_e state, next;
  alu_op_e op, kind;
  logic [DATA_W-1:0] core_y, acc, acc_next, load_val;
  logic [SW-1:0] cnt, amt;
  logic start_shift;
  alu_comb_core #(.DATA_W(DATA_W)) u_core (.op(op), .a(src_a), .b(src_b), .y(core_y));
  assign op = alu_op_e'(operation);
  assign amt = src_b[SW-1:0];
  assign start_shift = is_shift(op) && amt != '0;
  // a zero-amount shift completes immediately with the unshifted operand
  assign load_val = is_shift(op) ? src_a : core_y;
  assign acc_next = kind == OP_SLL ? acc << 1
                  : kind == OP_SRA ? {acc[DATA_W-1], acc[DATA_W-1:1]}
                  : acc >> 1;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
    case (state)
      IDLE:    next = in_valid ? (start_shift ? SHIFT : DONE) : IDLE;
      SHIFT:   next = cnt == SW'(1) ? DONE : SHIFT;
      DONE:    next = out_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      kind <= OP_SLL;
      result <= '0;
      zero <= 1'b1;
    end else if (state == IDLE && in_valid) begin
      if (start_shift) begin
        acc <= src_a;
        cnt <= amt;
        kind <= op;
      end else begin
        result <= load_val;
        zero <= load_val == '0;
      end
    end else if (state == SHIFT) begin
      acc <= acc_next;
      cnt <= cnt - SW'(1);
      if (cnt == SW'(1)) begin
        result <= acc_next;
        zero <= acc_next == '0;
      end
    end
  end
endmodule
